mdu: RTL and testbench
======================

MDU -- requirements
Module: mdu

Interface
REQ-001 SHALL provide port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 SHALL provide port reset, input, 1 bit: reset is synchronous and active-high.
REQ-003 SHALL provide port start, input, 1 bit: E-stage strobe; mdu_op, a and b are valid in a cycle where start=1.
REQ-004 SHALL provide port mdu_op, input, 3 bits, with encodings 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo; encoding 7 is treated as none.
REQ-005 SHALL provide port a, input, 32 bits: forwarded rs value.
REQ-006 SHALL provide port b, input, 32 bits: forwarded rt value.
REQ-007 SHALL provide port busy, output, 1 bit: high while an operation is in flight; the hazard unit stalls on mf/mt/md instructions when busy or start is high.
REQ-008 SHALL provide port hi, output, 32 bits: the architectural HI register, direct from a flop.
REQ-009 SHALL provide port lo, output, 32 bits: the architectural LO register, direct from a flop.

Parameters
REQ-010 SHALL provide parameter MULT_CYC, default 5: busy cycles for mult/multu.
REQ-011 SHALL provide parameter DIV_CYC, default 10: busy cycles for div/divu.

Function
REQ-012 SHALL implement an FSM with states IDLE and RUN, plus a 4-bit down-counter cnt; busy SHALL equal (state==RUN).
REQ-013 In IDLE, start with mult/multu SHALL compute the 64-bit product of a and b (signed for mult, unsigned for multu) into pending registers {phi,plo}, load cnt=MULT_CYC, and go to RUN.
REQ-014 In IDLE, start with div/divu SHALL compute quotient into plo and remainder into phi (signed for div, unsigned for divu), load cnt=DIV_CYC, and go to RUN.
REQ-015 Signed division SHALL truncate toward zero, with the remainder taking the sign of the dividend (e.g. -7/2 gives LO=-3, HI=-1).
REQ-016 0x80000000 / -1 under div SHALL yield LO=0x80000000 and HI=0 (wrap, no trap).
REQ-017 Division with b=0 SHALL still run DIV_CYC cycles and then leave hi/lo unchanged.
REQ-018 In RUN, cnt SHALL decrement each edge; on the edge where cnt goes 1->0, hi/lo SHALL take phi/plo and the FSM SHALL return to IDLE.
REQ-019 Timing: start sampled at edge k gives busy=1 for exactly N cycles after edge k and new hi/lo visible after edge k+N, the same edge on which busy falls.
REQ-020 In IDLE, start with mthi (or mtlo) SHALL write a into hi (or lo) at that edge, with no busy assertion and the other register unchanged.
REQ-021 start while in RUN SHALL be ignored entirely: no restart and no mthi/mtlo write.
REQ-022 start with op none or 7 SHALL have no effect.
REQ-023 Back-to-back operation: start may be accepted in the first IDLE cycle after busy falls.
REQ-024 hi and lo SHALL never change except per REQ-018 and REQ-020.

Reset
REQ-025 reset high at a clock edge SHALL force state=IDLE, cnt=0, hi=0, lo=0 and busy=0, and discard any pending phi/plo.
REQ-026 reset SHALL take priority over start and over an in-flight completion on the same edge, including reset asserted mid-operation.

Configuration
REQ-027 With macro MDU_DIV_EN defined, div/divu SHALL behave per REQ-014 to REQ-017.
REQ-028 With MDU_DIV_EN undefined, the divider logic SHALL be absent; div/divu SHALL be treated as none (no busy, hi/lo unchanged), and mult/multu/mthi/mtlo SHALL be unaffected.

Verification
REQ-029 reset; start mult a=0xFFFFFFFF b=2 -> busy high 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFE.
REQ-030 start multu a=0xFFFFFFFF b=2 -> after 5 cycles hi=0x00000001, lo=0xFFFFFFFE.
REQ-031 (MDU_DIV_EN) start div a=-7 b=2 -> busy 10 cycles, lo=0xFFFFFFFD, hi=0xFFFFFFFF; divu a=7 b=0 -> busy 10 cycles, hi/lo unchanged.
REQ-032 start mult, then in cycle 2 of busy start mthi a=0x1234 -> mthi ignored; final hi/lo are the mult result only.
REQ-033 start div, assert reset in cycle 4 -> next cycle busy=0, hi=lo=0, and no later update.
REQ-034 mtlo a=0xABCD in IDLE -> lo=0xABCD the next cycle, busy stays 0, hi unchanged; without MDU_DIV_EN, start div -> busy stays 0.

Source files
------------

// File: rtl/mdu.sv
// Multiply/divide unit owning the architectural HI/LO registers; mult/div commit after a fixed latency.
// Optional MDU_DIV_EN macro includes the div/divu datapath; without it div/divu act as no-ops.
module mdu #(
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  mdu_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;
    localparam logic [3:0] MULT_CNT = 4'(MULT_CYC);

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic [31:0] hi_q, lo_q, phi_q, plo_q;
    logic        commit_q;

    logic [63:0] prodSigned, prodUnsigned;
    logic [31:0] phi_d, plo_d;
    logic        commit_d;

    // Low 64 bits of a product of sign-extended operands equal the signed product.
    assign prodSigned   = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    assign prodUnsigned = {32'd0, a} * {32'd0, b};

`ifdef MDU_DIV_EN
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [3:0] DIV_CNT  = 4'(DIV_CYC);

    logic        divSigned, quoNeg, remNeg;
    logic [31:0] divN, divD, uQuo, uRem;

    // One unsigned divider on magnitudes; signs are restored afterwards so that
    // 0x80000000 / -1 wraps naturally to 0x80000000 with no special case.
    assign divSigned = (mdu_op == OP_DIV);
    assign divN      = (divSigned && a[31]) ? -a : a;
    assign divD      = (divSigned && b[31]) ? -b : b;
    assign uQuo      = (b == 32'd0) ? 32'd0 : divN / divD;
    assign uRem      = (b == 32'd0) ? 32'd0 : divN % divD;
    assign quoNeg    = divSigned && (a[31] ^ b[31]);
    assign remNeg    = divSigned && a[31];
`endif

    always_comb begin
        phi_d    = 32'd0;
        plo_d    = 32'd0;
        commit_d = 1'b1;
        case (mdu_op)
            OP_MULT:  {phi_d, plo_d} = prodSigned;
            OP_MULTU: {phi_d, plo_d} = prodUnsigned;
`ifdef MDU_DIV_EN
            OP_DIV, OP_DIVU: begin
                phi_d    = remNeg ? -uRem : uRem;
                plo_d    = quoNeg ? -uQuo : uQuo;
                commit_d = (b != 32'd0);
            end
`endif
            default: ;
        endcase
    end

    // Start is only honoured in IDLE; in RUN the counter alone decides completion.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            phi_q    <= 32'd0;
            plo_q    <= 32'd0;
            commit_q <= 1'b0;
        end else if (state_q == IDLE) begin
            if (start) begin
                case (mdu_op)
                    OP_MULT, OP_MULTU: begin
                        phi_q    <= phi_d;
                        plo_q    <= plo_d;
                        commit_q <= commit_d;
                        cnt_q    <= MULT_CNT;
                        state_q  <= RUN;
                    end
`ifdef MDU_DIV_EN
                    OP_DIV, OP_DIVU: begin
                        phi_q    <= phi_d;
                        plo_q    <= plo_d;
                        commit_q <= commit_d;
                        cnt_q    <= DIV_CNT;
                        state_q  <= RUN;
                    end
`endif
                    OP_MTHI: hi_q <= a;
                    OP_MTLO: lo_q <= a;
                    default: ;
                endcase
            end
        end else begin
            cnt_q <= cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
                state_q <= IDLE;
                if (commit_q) begin
                    hi_q <= phi_q;
                    lo_q <= plo_q;
                end
            end
        end
    end

    assign busy = (state_q == RUN);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: transaction-level HI/LO model checked every cycle, plus directed literal cases.
// Compile with MDU_DIV_EN defined to exercise the divider paths as well.
module tb_mdu;
    localparam int MULT_CYC = 5;
    localparam int DIV_CYC  = 10;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  mdu_op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int nChecks = 0;
    int nFails  = 0;

    mdu #(.MULT_CYC(MULT_CYC), .DIV_CYC(DIV_CYC)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .mdu_op(mdu_op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: an accepted operation is a transaction that completes on a
    // known future edge number; its result is computed with plain 64-bit arithmetic.
    int unsigned     cyc = 0;
    int unsigned     doneAt = 0;
    bit              mValid = 0;
    bit              inFlight = 0;
    bit              pendWrite = 0;
    logic [31:0]     mHi = 0, mLo = 0, pHi = 0, pLo = 0;
    longint          sa, sb, prodS;
    longint unsigned ua, ub, prodU;

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (reset) begin
            mValid   = 1;
            inFlight = 0;
            mHi      = 0;
            mLo      = 0;
        end else if (inFlight) begin
            if (cyc == doneAt) begin
                inFlight = 0;
                if (pendWrite) begin
                    mHi = pHi;
                    mLo = pLo;
                end
            end
        end else if (start) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            ua = a;
            ub = b;
            case (mdu_op)
                3'd1: begin
                    prodS = sa * sb;
                    pHi = prodS[63:32]; pLo = prodS[31:0];
                    pendWrite = 1; inFlight = 1; doneAt = cyc + MULT_CYC;
                end
                3'd2: begin
                    prodU = ua * ub;
                    pHi = prodU[63:32]; pLo = prodU[31:0];
                    pendWrite = 1; inFlight = 1; doneAt = cyc + MULT_CYC;
                end
`ifdef MDU_DIV_EN
                3'd3: begin
                    if (b != 0) begin
                        pLo = 32'(sa / sb);
                        pHi = 32'(sa % sb);
                    end
                    pendWrite = (b != 0); inFlight = 1; doneAt = cyc + DIV_CYC;
                end
                3'd4: begin
                    if (b != 0) begin
                        pLo = 32'(ua / ub);
                        pHi = 32'(ua % ub);
                    end
                    pendWrite = (b != 0); inFlight = 1; doneAt = cyc + DIV_CYC;
                end
`endif
                3'd5: mHi = a;
                3'd6: mLo = a;
                default: ;
            endcase
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at time %0t", name, actual, expected, $time);
        end
    endtask

    // Every cycle once the model has seen reset, the DUT must agree with it.
    always @(negedge clk) begin
        if (mValid) begin
            checkOutput("model.busy", {31'd0, busy}, {31'd0, inFlight});
            checkOutput("model.hi", hi, mHi);
            checkOutput("model.lo", lo, mLo);
        end
    end

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives start for exactly one edge; returns #1 after the edge that sampled it.
    task automatic applyStimulus(input logic [2:0] op, input logic [31:0] av, input logic [31:0] bv);
        @(posedge clk);
        #1;
        start  = 1'b1;
        mdu_op = op;
        a      = av;
        b      = bv;
        @(posedge clk);
        #1;
        start  = 1'b0;
        mdu_op = 3'd0;
        a      = $urandom;
        b      = $urandom;
    endtask

    function automatic logic [31:0] pickOperand();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($signed($urandom_range(0, 40)) - 20);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        mdu_op = 3'd0;
        a      = 32'd0;
        b      = 32'd0;
        waitCycles(2);
        reset = 1'b0;
        checkOutput("reset.busy", {31'd0, busy}, 32'd0);
        checkOutput("reset.hi", hi, 32'h0);
        checkOutput("reset.lo", lo, 32'h0);

        applyStimulus(3'd1, 32'hFFFF_FFFF, 32'd2);
        checkOutput("mult.busyFirst", {31'd0, busy}, 32'd1);
        waitCycles(MULT_CYC - 1);
        checkOutput("mult.busyLast", {31'd0, busy}, 32'd1);
        waitCycles(1);
        checkOutput("mult.busyDone", {31'd0, busy}, 32'd0);
        checkOutput("mult.hi", hi, 32'hFFFF_FFFF);
        checkOutput("mult.lo", lo, 32'hFFFF_FFFE);

        applyStimulus(3'd2, 32'hFFFF_FFFF, 32'd2);
        waitCycles(MULT_CYC);
        checkOutput("multu.hi", hi, 32'h0000_0001);
        checkOutput("multu.lo", lo, 32'hFFFF_FFFE);

        applyStimulus(3'd6, 32'h0000_ABCD, 32'd0);
        checkOutput("mtlo.busy", {31'd0, busy}, 32'd0);
        checkOutput("mtlo.lo", lo, 32'h0000_ABCD);
        checkOutput("mtlo.hi", hi, 32'h0000_0001);

        applyStimulus(3'd1, 32'd3, 32'hFFFF_FFFB);
        start = 1'b1; mdu_op = 3'd5; a = 32'h0000_1234;
        @(posedge clk);
        #1;
        start = 1'b0; mdu_op = 3'd0;
        checkOutput("mthiBusy.hiHeld", hi, 32'h0000_0001);
        waitCycles(MULT_CYC - 1);
        checkOutput("mthiBusy.hi", hi, 32'hFFFF_FFFF);
        checkOutput("mthiBusy.lo", lo, 32'hFFFF_FFF1);

`ifdef MDU_DIV_EN
        applyStimulus(3'd3, 32'hFFFF_FFF9, 32'd2);
        waitCycles(DIV_CYC - 1);
        checkOutput("div.busyLast", {31'd0, busy}, 32'd1);
        waitCycles(1);
        checkOutput("div.busyDone", {31'd0, busy}, 32'd0);
        checkOutput("div.lo", lo, 32'hFFFF_FFFD);
        checkOutput("div.hi", hi, 32'hFFFF_FFFF);

        applyStimulus(3'd4, 32'd7, 32'd0);
        waitCycles(DIV_CYC - 1);
        checkOutput("divz.busyLast", {31'd0, busy}, 32'd1);
        waitCycles(1);
        checkOutput("divz.hi", hi, 32'hFFFF_FFFF);
        checkOutput("divz.lo", lo, 32'hFFFF_FFFD);

        applyStimulus(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        waitCycles(DIV_CYC);
        checkOutput("divovf.lo", lo, 32'h8000_0000);
        checkOutput("divovf.hi", hi, 32'h0000_0000);

        applyStimulus(3'd3, 32'd100, 32'd7);
`else
        applyStimulus(3'd3, 32'hFFFF_FFF9, 32'd2);
        checkOutput("divOff.busy", {31'd0, busy}, 32'd0);
        checkOutput("divOff.hi", hi, 32'hFFFF_FFFF);
        checkOutput("divOff.lo", lo, 32'hFFFF_FFF1);

        applyStimulus(3'd1, 32'd100, 32'd7);
`endif
        waitCycles(2);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        checkOutput("midReset.busy", {31'd0, busy}, 32'd0);
        checkOutput("midReset.hi", hi, 32'h0);
        checkOutput("midReset.lo", lo, 32'h0);
        waitCycles(DIV_CYC + 2);
        checkOutput("midReset.hiLater", hi, 32'h0);
        checkOutput("midReset.loLater", lo, 32'h0);

        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #1;
            reset  = ($urandom_range(0, 63) == 0);
            start  = ($urandom_range(0, 2) == 0);
            mdu_op = 3'($urandom_range(0, 7));
            a      = pickOperand();
            b      = pickOperand();
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        start = 1'b0;
        waitCycles(2);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
